uart_tx_engine: RTL and testbench
=================================

Name: uart_tx_engine

Overview:
UART transmitter, the send-side counterpart of the receive control path in the UART block. It accepts a parallel byte through a load/ready handshake and serialises it as start bit, 8 data bits LSB first, optional parity, and stop bit. Bit timing comes from an internal bit-time counter using the same BIT_TIME convention as the receiver. It sits between the CPU-side transmit register and the Tx pin.

Parameters:
BIT_TIME, 5208, clocks per bit (50 MHz / 9600 baud); must be >= 2
DATA_W, 8, data bits per frame; fixed at 8 in this revision
PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-high reset
load  in  1  one-cycle strobe; accept data_in when tx_rdy = 1
data_in  in  8  byte to transmit
Tx  out  1  serial line, idle high, registered
tx_rdy  out  1  high when a new byte can be loaded
tx_done  out  1  one-cycle pulse on the last cycle of the stop bit

Behaviour:
- One clock (clk); reset is asynchronous and active-high (reset).
- Reset values: Tx = 1, tx_rdy = 1, tx_done = 0, state IDLE, counters 0, shift register 0.
- Reset mid-frame aborts the frame. Tx returns high immediately (asynchronously), and no tx_done pulse is issued.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE: Tx = 1, tx_rdy = 1.
  - load = 1 latches data_in into the shift register and clears the bit counter.
  - Next cycle: state = START, Tx = 0, tx_rdy = 0.
- Bit timer:
  - Counts 0..BIT_TIME-1 and resets on every state entry.
  - btu = (count == BIT_TIME-1).
  - Every bit lasts exactly BIT_TIME cycles on Tx.
- START, on btu: go to DATA and drive shift[0].
- DATA, on btu:
  - Shift right and increment the bit counter (3 bits).
  - After the 8th bit (counter == 7 at btu), go to PARITY if compiled in, else STOP.
- STOP: Tx = 1.
  - On btu: tx_done = 1 for that cycle, tx_rdy = 1 on the same cycle, state returns to IDLE.
- Back-to-back: a load coincident with tx_done is accepted. The next start bit begins on the following cycle, so there is zero idle gap beyond one stop bit.
- load while tx_rdy = 0 is ignored. Data and timing are unaffected and no error is flagged.
- Frame length from load to tx_done inclusive: 10*BIT_TIME cycles, or 11*BIT_TIME with parity.
- Tx is driven from a flop with no combinational path from inputs.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: a parity bit is inserted after data bit 7 for BIT_TIME cycles.
  - Value = XOR of the 8 data bits, XOR PARITY_ODD.
  - Parity is computed from the latched byte at load.
- Undefined: the PARITY state, parity register and logic are absent. DATA goes directly to STOP, and PARITY_ODD is ignored.

Decomposition:
- Shared package uart_pkg:
  - state enum encoding (IDLE, START, DATA, PARITY, STOP)
  - DATA_W constant
  - line-level constants IDLE_LVL = 1, START_LVL = 0
  - These are shared with the receive FSM.
- One sub-module, uart_bit_timer: parameter BIT_TIME; inputs clk, reset, clr; output btu. It is reused by the receiver's Btu generation.

Test Plan:
- BIT_TIME = 16, reset held 100 ns then released -> Tx = 1, tx_rdy = 1, tx_done = 0. Idle 50 cycles with no toggles.
- load with data_in = 0x55 -> Tx low one cycle after load for 16 cycles, then bits 1,0,1,0,1,0,1,0 at 16 cycles each, stop high 16. tx_done pulses at cycle 160, tx_rdy rises on the same cycle.
- load 0xA3 pulsed on the tx_done cycle of a prior 0x0F frame -> next start bit on the following cycle. Decoded frames are 0x0F then 0xA3 with no extra idle.
- load 0xFF mid-frame (during DATA) -> ignored; the in-flight byte 0x55 is transmitted unchanged and tx_rdy stays low.
- reset asserted at cycle 70 of a 0x00 frame -> Tx = 1 asynchronously and tx_rdy = 1. No tx_done; the next load of 0x81 transmits correctly.
- With UART_TX_PARITY_EN and PARITY_ODD = 0, load 0x07 -> parity bit 1, frame 176 cycles. With PARITY_ODD = 1 -> parity bit 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM state encoding and line levels,
// common to the transmit engine and the receive control path.
package uart_pkg;

    localparam int DATA_W = 8;

    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_LVL = 1'b0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..BIT_TIME-1 and raises btu on the last clock of
// each bit. clr holds the count at zero so every state entry starts a fresh bit.
module uart_bit_timer #(
    parameter int BIT_TIME = 5208
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic btu
);

    localparam int CW = $clog2(BIT_TIME);

    logic [CW-1:0] count;

    assign btu = (count == CW'(BIT_TIME - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr || btu) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, stop bit.
// Parity (and the PARITY_ODD parameter) exist only when UART_TX_PARITY_EN is defined.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int BIT_TIME = 5208
`ifdef UART_TX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    output logic              Tx,
    output logic              tx_rdy,
    output logic              tx_done
);

    uart_state_t       state, state_nx;
    logic [DATA_W-1:0] shift, shift_nx;
    logic [2:0]        bit_cnt, bit_cnt_nx;
    logic              tx_nx;
    logic              btu;

    // The timer is held cleared while idle, so START always begins at count 0.
    uart_bit_timer #(
        .BIT_TIME (BIT_TIME)
    ) u_bit_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (state == IDLE),
        .btu   (btu)
    );

`ifdef UART_TX_PARITY_EN
    logic parity_bit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_bit <= 1'b0;
        end else if (tx_rdy && load) begin
            parity_bit <= (^data_in) ^ PARITY_ODD;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            Tx      <= IDLE_LVL;
        end else begin
            state   <= state_nx;
            shift   <= shift_nx;
            bit_cnt <= bit_cnt_nx;
            Tx      <= tx_nx;
        end
    end

    // The last stop-bit cycle doubles as a load slot for back-to-back frames.
    always_comb begin
        state_nx   = state;
        shift_nx   = shift;
        bit_cnt_nx = bit_cnt;
        tx_rdy     = 1'b0;
        tx_done    = 1'b0;
        case (state)
            IDLE: begin
                tx_rdy = 1'b1;
                if (load) begin
                    state_nx   = START;
                    shift_nx   = data_in;
                    bit_cnt_nx = '0;
                end
            end
            START: begin
                if (btu) begin
                    state_nx = DATA;
                end
            end
            DATA: begin
                if (btu) begin
                    shift_nx   = shift >> 1;
                    bit_cnt_nx = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (btu) begin
                    state_nx = STOP;
                end
            end
`endif
            STOP: begin
                if (btu) begin
                    tx_done  = 1'b1;
                    tx_rdy   = 1'b1;
                    state_nx = IDLE;
                    if (load) begin
                        state_nx   = START;
                        shift_nx   = data_in;
                        bit_cnt_nx = '0;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Line level is decoded from the next state so Tx comes straight off a flop.
    always_comb begin
        tx_nx = IDLE_LVL;
        case (state_nx)
            START:   tx_nx = START_LVL;
            DATA:    tx_nx = shift_nx[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_nx = parity_bit;
`endif
            default: tx_nx = IDLE_LVL;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed testbench for uart_tx_engine at BIT_TIME = 16; with UART_TX_PARITY_EN
// a second instance with odd parity runs alongside the even-parity one.
module tb_uart_tx_engine;

    localparam int BT = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11 * BT;
`else
    localparam int FRAME = 10 * BT;
`endif

    logic       clk;
    logic       reset;
    logic       load;
    logic [7:0] data_in;
    logic       Tx;
    logic       tx_rdy;
    logic       tx_done;

    int errors = 0;
    int checks = 0;

    logic [FRAME:1] tr_tx;
    logic [FRAME:1] tr_done;
    logic [FRAME:1] tr_rdy;

    uart_tx_engine #(
        .BIT_TIME (BT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .data_in (data_in),
        .Tx      (Tx),
        .tx_rdy  (tx_rdy),
        .tx_done (tx_done)
    );

`ifdef UART_TX_PARITY_EN
    logic           Tx2;
    logic           tx_rdy2;
    logic           tx_done2;
    logic [FRAME:1] tr_tx2;
    logic [FRAME:1] tr_done2;

    uart_tx_engine #(
        .BIT_TIME   (BT),
        .PARITY_ODD (1'b1)
    ) dut_odd (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .data_in (data_in),
        .Tx      (Tx2),
        .tx_rdy  (tx_rdy2),
        .tx_done (tx_done2)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle k counts from 1 = first cycle after the edge that sampled load.
    function automatic logic exp_tx(input logic [7:0] b, input bit odd, input int k);
        if (k <= BT) return 1'b0;
        if (k <= 9 * BT) return b[(k - BT - 1) / BT];
`ifdef UART_TX_PARITY_EN
        if (k <= 10 * BT) return (^b) ^ odd;
`endif
        return 1'b1;
    endfunction

    function automatic int first_tx_err(input logic [FRAME:1] t, input logic [7:0] b, input bit odd);
        for (int k = 1; k <= FRAME; k++) begin
            if (t[k] !== exp_tx(b, odd, k)) return k;
        end
        return 0;
    endfunction

    function automatic int first_pulse_err(input logic [FRAME:1] t, input int at);
        for (int k = 1; k <= FRAME; k++) begin
            if (t[k] !== (k == at)) return k;
        end
        return 0;
    endfunction

    task automatic start_frame(input logic [7:0] b);
        load    = 1'b1;
        data_in = b;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic capture_frame(input int inject, input logic [7:0] ib);
        for (int k = 1; k <= FRAME; k++) begin
            if (k == inject) begin
                load    = 1'b1;
                data_in = ib;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
            tr_tx[k]   = Tx;
            tr_done[k] = tx_done;
            tr_rdy[k]  = tx_rdy;
`ifdef UART_TX_PARITY_EN
            tr_tx2[k]   = Tx2;
            tr_done2[k] = tx_done2;
`endif
            @(posedge clk);
            #1;
        end
        load = 1'b0;
    endtask

    task automatic test_reset();
        int toggles;
        int bad;
        logic prev;
        reset   = 1'b1;
        load    = 1'b0;
        data_in = 8'h00;
        #100;
        reset = 1'b0;
        #1;
        checks++;
        if (Tx !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx: got %b want 1", Tx); end
        checks++;
        if (tx_rdy !== 1'b1) begin errors++; $display("[TB] FAIL reset_rdy: got %b want 1", tx_rdy); end
        checks++;
        if (tx_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", tx_done); end
        toggles = 0;
        bad     = 0;
        prev    = Tx;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (Tx !== prev) toggles++;
            prev = Tx;
            if (tx_rdy !== 1'b1 || tx_done !== 1'b0) bad++;
        end
        checks++;
        if (toggles !== 0) begin errors++; $display("[TB] FAIL idle_toggles: got %0d want 0", toggles); end
        checks++;
        if (bad !== 0) begin errors++; $display("[TB] FAIL idle_flags: %0d bad cycles want 0", bad); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_frame();
        int c;
        start_frame(8'h55);
        capture_frame(0, 8'h00);
        c = first_tx_err(tr_tx, 8'h55, 1'b0);
        checks++;
        if (c !== 0) begin errors++; $display("[TB] FAIL wave_55: cycle %0d Tx=%b want %b", c, tr_tx[c], exp_tx(8'h55, 1'b0, c)); end
        c = first_pulse_err(tr_done, FRAME);
        checks++;
        if (c !== 0) begin errors++; $display("[TB] FAIL done_55: cycle %0d tx_done=%b want %b", c, tr_done[c], c == FRAME); end
        c = first_pulse_err(tr_rdy, FRAME);
        checks++;
        if (c !== 0) begin errors++; $display("[TB] FAIL rdy_55: cycle %0d tx_rdy=%b want %b", c, tr_rdy[c], c == FRAME); end
    endtask

    task automatic test_back_to_back();
        int c;
        start_frame(8'h0F);
        capture_frame(FRAME, 8'hA3);
        c = first_tx_err(tr_tx, 8'h0F, 1'b0);
        checks++;
        if (c !== 0) begin errors++; $display("[TB] FAIL wave_0f: cycle %0d Tx=%b want %b", c, tr_tx[c], exp_tx(8'h0F, 1'b0, c)); end
        c = first_pulse_err(tr_done, FRAME);
        checks++;
        if (c !== 0) begin errors++; $display("[TB] FAIL done_0f: cycle %0d tx_done=%b want %b", c, tr_done[c], c == FRAME); end
        c = first_pulse_err(tr_rdy, FRAME);
        checks++;
        if (c !== 0) begin errors++; $display("[TB] FAIL rdy_0f: cycle %0d tx_rdy=%b want %b", c, tr_rdy[c], c == FRAME); end
        capture_frame(0, 8'h00);
        c = first_tx_err(tr_tx, 8'hA3, 1'b0);
        checks++;
        if (c !== 0) begin errors++; $display("[TB] FAIL wave_a3: cycle %0d Tx=%b want %b", c, tr_tx[c], exp_tx(8'hA3, 1'b0, c)); end
        c = first_pulse_err(tr_done, FRAME);
        checks++;
        if (c !== 0) begin errors++; $display("[TB] FAIL done_a3: cycle %0d tx_done=%b want %b", c, tr_done[c], c == FRAME); end
        c = first_pulse_err(tr_rdy, FRAME);
        checks++;
        if (c !== 0) begin errors++; $display("[TB] FAIL rdy_a3: cycle %0d tx_rdy=%b want %b", c, tr_rdy[c], c == FRAME); end
    endtask

    task automatic test_ignored_load();
        int c;
        start_frame(8'h55);
        capture_frame(40, 8'hFF);
        c = first_tx_err(tr_tx, 8'h55, 1'b0);
        checks++;
        if (c !== 0) begin errors++; $display("[TB] FAIL wave_ignored: cycle %0d Tx=%b want %b", c, tr_tx[c], exp_tx(8'h55, 1'b0, c)); end
        c = first_pulse_err(tr_rdy, FRAME);
        checks++;
        if (c !== 0) begin errors++; $display("[TB] FAIL rdy_ignored: cycle %0d tx_rdy=%b want %b", c, tr_rdy[c], c == FRAME); end
        @(negedge clk);
        checks++;
        if (Tx !== 1'b1) begin errors++; $display("[TB] FAIL idle_after_ignored_tx: got %b want 1", Tx); end
        checks++;
        if (tx_rdy !== 1'b1) begin errors++; $display("[TB] FAIL idle_after_ignored_rdy: got %b want 1", tx_rdy); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_mid_frame_reset();
        int c;
        int early_done;
        start_frame(8'h00);
        early_done = 0;
        for (int k = 1; k < 70; k++) begin
            @(negedge clk);
            if (tx_done !== 1'b0) early_done++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (early_done !== 0) begin errors++; $display("[TB] FAIL early_done: %0d pulses want 0", early_done); end
        #2;
        checks++;
        if (Tx !== 1'b0) begin errors++; $display("[TB] FAIL pre_reset_tx: got %b want 0", Tx); end
        reset = 1'b1;
        #1;
        checks++;
        if (Tx !== 1'b1) begin errors++; $display("[TB] FAIL async_reset_tx: got %b want 1", Tx); end
        checks++;
        if (tx_rdy !== 1'b1) begin errors++; $display("[TB] FAIL async_reset_rdy: got %b want 1", tx_rdy); end
        checks++;
        if (tx_done !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_done: got %b want 0", tx_done); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        start_frame(8'h81);
        capture_frame(0, 8'h00);
        c = first_tx_err(tr_tx, 8'h81, 1'b0);
        checks++;
        if (c !== 0) begin errors++; $display("[TB] FAIL wave_81: cycle %0d Tx=%b want %b", c, tr_tx[c], exp_tx(8'h81, 1'b0, c)); end
        c = first_pulse_err(tr_done, FRAME);
        checks++;
        if (c !== 0) begin errors++; $display("[TB] FAIL done_81: cycle %0d tx_done=%b want %b", c, tr_done[c], c == FRAME); end
        c = first_pulse_err(tr_rdy, FRAME);
        checks++;
        if (c !== 0) begin errors++; $display("[TB] FAIL rdy_81: cycle %0d tx_rdy=%b want %b", c, tr_rdy[c], c == FRAME); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int c;
        start_frame(8'h07);
        capture_frame(0, 8'h00);
        checks++;
        if (tr_tx[150] !== 1'b1) begin errors++; $display("[TB] FAIL parity_even_bit: got %b want 1", tr_tx[150]); end
        checks++;
        if (tr_tx2[150] !== 1'b0) begin errors++; $display("[TB] FAIL parity_odd_bit: got %b want 0", tr_tx2[150]); end
        c = first_tx_err(tr_tx, 8'h07, 1'b0);
        checks++;
        if (c !== 0) begin errors++; $display("[TB] FAIL wave_07_even: cycle %0d Tx=%b want %b", c, tr_tx[c], exp_tx(8'h07, 1'b0, c)); end
        c = first_tx_err(tr_tx2, 8'h07, 1'b1);
        checks++;
        if (c !== 0) begin errors++; $display("[TB] FAIL wave_07_odd: cycle %0d Tx=%b want %b", c, tr_tx2[c], exp_tx(8'h07, 1'b1, c)); end
        c = first_pulse_err(tr_done, FRAME);
        checks++;
        if (c !== 0) begin errors++; $display("[TB] FAIL done_07_even: cycle %0d tx_done=%b want %b", c, tr_done[c], c == FRAME); end
        c = first_pulse_err(tr_done2, FRAME);
        checks++;
        if (c !== 0) begin errors++; $display("[TB] FAIL done_07_odd: cycle %0d tx_done=%b want %b", c, tr_done2[c], c == FRAME); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_ignored_load();
        test_mid_frame_reset();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
